// File: rtl/or1_serial_loader_if.sv
// Boot-loader pin bundle: serial input and LOAD on one side, memory write port and core control on the other.
// The master modport is the loader itself; the slave modport is whatever drives RXD/LOAD and consumes the writes.
interface or1_serial_loader_if #(
    parameter int ADDR_W = 8
);
    logic              RXD;
    logic              LOAD;
    logic              WE;
    logic [ADDR_W-1:0] WADDR;
    logic [7:0]        WDATA;
    logic              CPU_RST;
    logic              DONE;
    logic              ERR;

    modport master (
        input  RXD, LOAD,
        output WE, WADDR, WDATA, CPU_RST, DONE, ERR
    );

    modport slave (
        output RXD, LOAD,
        input  WE, WADDR, WDATA, CPU_RST, DONE, ERR
    );
endinterface

// File: rtl/or1_serial_loader.sv
// Serial boot loader: 8N1 receiver feeding a length-prefixed writer into program memory, holding the core in reset until done.
// WE follows the stop-bit sample by one cycle; DONE/CPU_RST release one cycle after the last WE. No backpressure: memory must accept every WE.
module or1_serial_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    or1_serial_loader_if.master  bus
);
    localparam int TW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LEN_W = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BRK} rx_state_t;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE} ld_state_t;

    logic              rxd_s1_q, rxd_s1_d;
    logic              rxd_s2_q, rxd_s2_d;
    logic              rxd_s3_q, rxd_s3_d;
    rx_state_t         rx_state_q, rx_state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [2:0]        nbit_q, nbit_d;
    logic [7:0]        shift_q, shift_d;
    ld_state_t         ld_state_q, ld_state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic byte_vld;
    logic frame_err;
    logic tick_end;
    logic half_end;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_s3_q   <= 1'b1;
            rx_state_q <= R_IDLE;
            tick_q     <= '0;
            nbit_q     <= '0;
            shift_q    <= '0;
            ld_state_q <= L_LEN;
            rem_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rxd_s1_q   <= rxd_s1_d;
            rxd_s2_q   <= rxd_s2_d;
            rxd_s3_q   <= rxd_s3_d;
            rx_state_q <= rx_state_d;
            tick_q     <= tick_d;
            nbit_q     <= nbit_d;
            shift_q    <= shift_d;
            ld_state_q <= ld_state_d;
            rem_q      <= rem_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tick_end = (tick_q == TW'(CLKS_PER_BIT - 1));
    assign half_end = (tick_q == TW'(CLKS_PER_BIT / 2 - 1));

    // Receiver; rxd_s3_q is the previous synced sample, used only for start-edge detection.
    always_comb begin
        rxd_s1_d   = bus.RXD;
        rxd_s2_d   = rxd_s1_q;
        rxd_s3_d   = rxd_s2_q;
        rx_state_d = rx_state_q;
        tick_d     = tick_q;
        nbit_d     = nbit_q;
        shift_d    = shift_q;
        byte_vld   = 1'b0;
        frame_err  = 1'b0;

        case (rx_state_q)
            R_IDLE: begin
                if (rxd_s3_q && !rxd_s2_q) begin
                    rx_state_d = R_START;
                    tick_d     = '0;
                    nbit_d     = '0;
                end
            end
            R_START: begin
                if (half_end) begin
                    tick_d     = '0;
                    rx_state_d = rxd_s2_q ? R_IDLE : R_DATA;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            R_DATA: begin
                if (tick_end) begin
                    tick_d  = '0;
                    shift_d = {rxd_s2_q, shift_q[7:1]};
                    nbit_d  = nbit_q + 3'd1;
                    if (nbit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            R_STOP: begin
                if (tick_end) begin
                    tick_d = '0;
                    if (rxd_s2_q) begin
                        byte_vld   = 1'b1;
                        rx_state_d = R_IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        rx_state_d = R_BRK;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            R_BRK: begin
                if (rxd_s2_q) begin
                    rx_state_d = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase

        if (bus.LOAD) begin
            rx_state_d = R_IDLE;
            tick_d     = '0;
            nbit_d     = '0;
        end
    end

    // Loader; the address advances the cycle after each write so WE and WADDR stay aligned.
    always_comb begin
        ld_state_d = ld_state_q;
        rem_d      = rem_q;
        waddr_d    = we_q ? waddr_q + ADDR_W'(1) : waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        err_d      = err_q | frame_err;
        done_d     = (ld_state_q == L_DONE);
        cpu_rst_d  = (ld_state_q != L_DONE);

        case (ld_state_q)
            L_LEN: begin
                if (byte_vld) begin
                    rem_d      = (shift_q == 8'd0) ? (LEN_W'(1) << ADDR_W) : LEN_W'(shift_q);
                    waddr_d    = '0;
                    ld_state_d = L_DATA;
                end
            end
            L_DATA: begin
                if (byte_vld) begin
                    we_d    = 1'b1;
                    wdata_d = shift_q;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        ld_state_d = L_DONE;
                    end
                end
            end
            L_DONE: begin
            end
            default: ld_state_d = L_LEN;
        endcase

        if (bus.LOAD) begin
            ld_state_d = L_LEN;
            we_d       = 1'b0;
            waddr_d    = '0;
            err_d      = 1'b0;
            done_d     = 1'b0;
            cpu_rst_d  = 1'b1;
        end
    end

    assign bus.WE      = we_q;
    assign bus.WADDR   = waddr_q;
    assign bus.WDATA   = wdata_q;
    assign bus.CPU_RST = cpu_rst_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;
endmodule

// File: tb/tb_or1_serial_loader.sv
// Directed bench for or1_serial_loader: frames are bit-banged on RXD and every WE is logged for comparison
// against hand-computed expected writes and flag values.
module tb_or1_serial_loader;
    localparam int CPB    = 4;
    localparam int ADDR_W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    or1_serial_loader_if #(.ADDR_W(ADDR_W)) bus ();

    or1_serial_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W)
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wa[$];
    logic [7:0]  wd[$];
    int unsigned cyc = 0;
    int unsigned last_we_cyc = 0;
    int unsigned done_rise_cyc = 0;
    logic        done_prev = 1'b0;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (bus.WE === 1'b1) begin
            wa.push_back(bus.WADDR);
            wd.push_back(bus.WDATA);
            last_we_cyc = cyc;
        end
        if (bus.DONE === 1'b1 && done_prev !== 1'b1) begin
            done_rise_cyc = cyc;
        end
        done_prev = bus.DONE;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        bus.RXD = v;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        bit_out(1'b1);
        bit_out(1'b1);
    endtask

    task automatic pulse_load();
        bus.LOAD = 1'b1;
        @(negedge CLK);
        bus.LOAD = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.RXD  = 1'b1;
        bus.LOAD = 1'b0;
        RST      = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_we",      bus.WE,      0);
        chk("rst_waddr",   bus.WADDR,   0);
        chk("rst_wdata",   bus.WDATA,   0);
        chk("rst_cpu_rst", bus.CPU_RST, 1);
        chk("rst_done",    bus.DONE,    0);
        chk("rst_err",     bus.ERR,     0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // 1: basic load of three bytes
        clear_log();
        send_frame(8'h03, 1'b1);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (4) @(negedge CLK);
        chk("t1_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("t1_a0", wa[0], 8'h00); chk("t1_d0", wd[0], 8'hA5);
            chk("t1_a1", wa[1], 8'h01); chk("t1_d1", wd[1], 8'h3C);
            chk("t1_a2", wa[2], 8'h02); chk("t1_d2", wd[2], 8'hFF);
        end
        chk("t1_done",     bus.DONE,    1);
        chk("t1_cpu_rst",  bus.CPU_RST, 0);
        chk("t1_err",      bus.ERR,     0);
        chk("t1_waddr",    bus.WADDR,   3);
        chk("t1_done_lat", done_rise_cyc - last_we_cyc, 1);

        // 2: framing error on the first payload byte is dropped
        pulse_load();
        chk("t2_load_cpu_rst", bus.CPU_RST, 1);
        chk("t2_load_done",    bus.DONE,    0);
        chk("t2_load_waddr",   bus.WADDR,   0);
        clear_log();
        send_frame(8'h02, 1'b1);
        send_frame(8'h11, 1'b0);
        chk("t2_err_set", bus.ERR, 1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        repeat (4) @(negedge CLK);
        chk("t2_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("t2_a0", wa[0], 8'h00); chk("t2_d0", wd[0], 8'h22);
            chk("t2_a1", wa[1], 8'h01); chk("t2_d1", wd[1], 8'h33);
        end
        chk("t2_err",  bus.ERR,  1);
        chk("t2_done", bus.DONE, 1);

        // 3: one-cycle glitch must not start a frame
        pulse_load();
        chk("t3_err_clr", bus.ERR, 0);
        clear_log();
        bus.RXD = 1'b0;
        @(negedge CLK);
        bus.RXD = 1'b1;
        repeat (50) @(negedge CLK);
        chk("t3_nwr",  wa.size(), 0);
        chk("t3_err",  bus.ERR,   0);
        chk("t3_done", bus.DONE,  0);
        send_frame(8'h01, 1'b1);
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge CLK);
        chk("t3_nwr2", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("t3_a0", wa[0], 8'h00); chk("t3_d0", wd[0], 8'h5A);
        end
        chk("t3_done2", bus.DONE, 1);

        // 4: LOAD in the middle of a load restarts it
        pulse_load();
        clear_log();
        send_frame(8'h04, 1'b1);
        send_frame(8'h10, 1'b1);
        send_frame(8'h20, 1'b1);
        chk("t4_mid_cpu_rst", bus.CPU_RST, 1);
        chk("t4_mid_waddr",   bus.WADDR,   2);
        pulse_load();
        chk("t4_load_cpu_rst", bus.CPU_RST, 1);
        chk("t4_load_waddr",   bus.WADDR,   0);
        send_frame(8'h01, 1'b1);
        chk("t4_cpu_rst_hold", bus.CPU_RST, 1);
        send_frame(8'h77, 1'b1);
        repeat (4) @(negedge CLK);
        chk("t4_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("t4_a_last", wa[2], 8'h00); chk("t4_d_last", wd[2], 8'h77);
        end
        chk("t4_done",    bus.DONE,    1);
        chk("t4_cpu_rst", bus.CPU_RST, 0);

        // 5: count 0 means a full 256-byte image
        pulse_load();
        clear_log();
        send_frame(8'h00, 1'b1);
        for (int i = 0; i < 255; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 254) chk("t5_not_done_early", bus.DONE, 0);
        end
        send_frame(8'hFF, 1'b1);
        repeat (4) @(negedge CLK);
        chk("t5_nwr", wa.size(), 256);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < wa.size(); i++) begin
                if (wa[i] !== 8'(i) || wd[i] !== 8'(i)) bad++;
            end
            chk("t5_bad_entries", bad, 0);
        end
        chk("t5_done",     bus.DONE,  1);
        chk("t5_waddr",    bus.WADDR, 0);
        chk("t5_done_lat", done_rise_cyc - last_we_cyc, 1);

        // 6: asynchronous reset mid data bit of the 2nd payload byte
        pulse_load();
        clear_log();
        send_frame(8'h03, 1'b1);
        send_frame(8'hAB, 1'b1);
        chk("t6_pre_nwr", wa.size(), 1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bus.RXD = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("t6_rst_we",      bus.WE,      0);
        chk("t6_rst_waddr",   bus.WADDR,   0);
        chk("t6_rst_wdata",   bus.WDATA,   0);
        chk("t6_rst_cpu_rst", bus.CPU_RST, 1);
        chk("t6_rst_done",    bus.DONE,    0);
        chk("t6_rst_err",     bus.ERR,     0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (30) @(negedge CLK);
        chk("t6_post_nwr", wa.size(), 1);
        clear_log();
        send_frame(8'h01, 1'b1);
        send_frame(8'hC3, 1'b1);
        repeat (4) @(negedge CLK);
        chk("t6_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("t6_a0", wa[0], 8'h00); chk("t6_d0", wd[0], 8'hC3);
        end
        chk("t6_done",    bus.DONE,    1);
        chk("t6_cpu_rst", bus.CPU_RST, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
